// File: rtl/peak_trough_tracker.sv
// Hysteresis peak/trough detector with refractory gap and saturating counts.
// Optional inter-peak interval measurement, compiled in when PEAK_INTERVAL_EN is defined.
module peak_trough_tracker #(
   parameter int WIDTH   = 10,
   parameter int HYST    = 8,
   parameter int MIN_GAP = 4,
   parameter int CNT_W   = 10,
   parameter int INT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   input  logic             clear,
   output logic             peak_pulse,
   output logic             trough_pulse,
   output logic [CNT_W-1:0] num_peaks,
   output logic [CNT_W-1:0] num_troughs,
   output logic [INT_W-1:0] interval,
   output logic             interval_valid
);

   localparam logic [1:0] INIT    = 2'd0;
   localparam logic [1:0] SEEK    = 2'd1;
   localparam logic [1:0] RISING  = 2'd2;
   localparam logic [1:0] FALLING = 2'd3;

   localparam int               GAP_W   = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);
   localparam logic [WIDTH:0]   HYST_X  = (WIDTH + 1)'(HYST);

   logic [1:0]       state, state_nx;
   logic [WIDTH-1:0] ext, ext_nx;
   logic [GAP_W-1:0] gap, gap_inc, gap_nx;
   logic [WIDTH:0]   samp_x, ext_x;
   logic             up_hit, dn_hit;
   logic             peak_ev, trough_ev;

   // One extra bit keeps ext+HYST and sample+HYST from wrapping.
   assign samp_x  = {1'b0, sample};
   assign ext_x   = {1'b0, ext};
   assign up_hit  = samp_x >= ext_x + HYST_X;
   assign dn_hit  = samp_x + HYST_X <= ext_x;
   assign gap_inc = (gap >= GAP_MAX) ? GAP_MAX : gap + GAP_W'(1);

   always_comb begin
      state_nx  = state;
      ext_nx    = ext;
      gap_nx    = gap;
      peak_ev   = 1'b0;
      trough_ev = 1'b0;
      if (sample_valid) begin
         // The refractory check uses the gap including the current sample.
         gap_nx = gap_inc;
         case (state)
            INIT: begin
               ext_nx   = sample;
               state_nx = SEEK;
            end
            SEEK: begin
               if (up_hit) begin
                  state_nx = RISING;
                  ext_nx   = sample;
               end else if (dn_hit) begin
                  state_nx = FALLING;
                  ext_nx   = sample;
               end
            end
            RISING: begin
               if (sample > ext) begin
                  ext_nx = sample;
               end else if (dn_hit && gap_inc >= GAP_MAX) begin
                  peak_ev  = 1'b1;
                  state_nx = FALLING;
                  ext_nx   = sample;
                  gap_nx   = '0;
               end
            end
            FALLING: begin
               if (sample < ext) begin
                  ext_nx = sample;
               end else if (up_hit && gap_inc >= GAP_MAX) begin
                  trough_ev = 1'b1;
                  state_nx  = RISING;
                  ext_nx    = sample;
                  gap_nx    = '0;
               end
            end
            default: state_nx = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         ext          <= '0;
         gap          <= GAP_MAX;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         num_peaks    <= '0;
         num_troughs  <= '0;
      end else if (clear) begin
         state        <= INIT;
         ext          <= '0;
         gap          <= GAP_MAX;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         num_peaks    <= '0;
         num_troughs  <= '0;
      end else begin
         state        <= state_nx;
         ext          <= ext_nx;
         gap          <= gap_nx;
         peak_pulse   <= peak_ev;
         trough_pulse <= trough_ev;
         if (peak_ev && num_peaks != '1)
            num_peaks <= num_peaks + CNT_W'(1);
         if (trough_ev && num_troughs != '1)
            num_troughs <= num_troughs + CNT_W'(1);
      end
   end

`ifdef PEAK_INTERVAL_EN
   logic [INT_W-1:0] icnt;
   logic             seen_peak;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         icnt           <= '0;
         seen_peak      <= 1'b0;
         interval       <= '0;
         interval_valid <= 1'b0;
      end else if (clear) begin
         icnt           <= '0;
         seen_peak      <= 1'b0;
         interval       <= '0;
         interval_valid <= 1'b0;
      end else begin
         interval_valid <= 1'b0;
         if (peak_ev) begin
            icnt      <= '0;
            seen_peak <= 1'b1;
            if (seen_peak) begin
               interval       <= (icnt == '1) ? icnt : icnt + INT_W'(1);
               interval_valid <= 1'b1;
            end
         end else if (sample_valid && icnt != '1) begin
            icnt <= icnt + INT_W'(1);
         end
      end
   end
`else
   assign interval       = '0;
   assign interval_valid = 1'b0;
`endif

endmodule

// File: tb/tb_peak_trough_tracker.sv
// Self-checking bench for peak_trough_tracker: default instance plus a CNT_W=2 instance,
// both checked against a behavioural model driven by directed and random sample streams.
module tb_peak_trough_tracker;

   localparam int WIDTH   = 10;
   localparam int HYST    = 8;
   localparam int MIN_GAP = 4;
   localparam int CNT_W   = 10;
   localparam int INT_W   = 16;
   localparam int IMAX    = 65535;

`ifdef PEAK_INTERVAL_EN
   localparam bit IEN = 1'b1;
`else
   localparam bit IEN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             sample_valid = 1'b0;
   logic             clear = 1'b0;
   logic [WIDTH-1:0] sample = '0;

   logic             peak_pulse, trough_pulse, interval_valid;
   logic [CNT_W-1:0] num_peaks, num_troughs;
   logic [INT_W-1:0] interval;
   logic             c2_pk, c2_tr, c2_iv;
   logic [1:0]       c2_np, c2_nt;
   logic [INT_W-1:0] c2_int;

   always #5 clk = ~clk;

   peak_trough_tracker #(.WIDTH(WIDTH), .HYST(HYST), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W), .INT_W(INT_W)) dut (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .clear(clear),
      .peak_pulse(peak_pulse), .trough_pulse(trough_pulse), .num_peaks(num_peaks),
      .num_troughs(num_troughs), .interval(interval), .interval_valid(interval_valid)
   );

   peak_trough_tracker #(.WIDTH(WIDTH), .HYST(HYST), .MIN_GAP(MIN_GAP), .CNT_W(2), .INT_W(INT_W)) dut_c2 (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .clear(clear),
      .peak_pulse(c2_pk), .trough_pulse(c2_tr), .num_peaks(c2_np),
      .num_troughs(c2_nt), .interval(c2_int), .interval_valid(c2_iv)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: direction of the current excursion and the extreme seen so far.
   bit m_have, m_seen, m_pk, m_tr, m_iv;
   int m_dir, m_ext, m_gap, m_icnt, m_np, m_nt, m_interval;

   logic [61:0] obs;
   assign obs = {peak_pulse, trough_pulse, num_peaks, num_troughs,
                 c2_pk, c2_tr, c2_np, c2_nt, interval_valid, interval, c2_iv, c2_int};

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [61:0] expv();
      logic [INT_W-1:0] ei;
      logic             eiv;
      ei  = IEN ? INT_W'(m_interval) : '0;
      eiv = IEN & m_iv;
      return {m_pk, m_tr, CNT_W'(sat(m_np, 1023)), CNT_W'(sat(m_nt, 1023)),
              m_pk, m_tr, 2'(sat(m_np, 3)), 2'(sat(m_nt, 3)), eiv, ei, eiv, ei};
   endfunction

   task automatic model_clear();
      m_have = 0; m_seen = 0; m_pk = 0; m_tr = 0; m_iv = 0;
      m_dir = 0; m_ext = 0; m_gap = MIN_GAP; m_icnt = 0;
      m_np = 0; m_nt = 0; m_interval = 0;
   endtask

   task automatic model_step(input bit v, input int s, input bit c);
      int  g;
      bit  pk, tr;
      m_pk = 0; m_tr = 0; m_iv = 0;
      if (c) begin
         model_clear();
         return;
      end
      if (!v) return;
      pk = 0; tr = 0;
      g = sat(m_gap + 1, MIN_GAP);
      if (!m_have) begin
         m_have = 1;
         m_ext  = s;
      end else if (m_dir == 0) begin
         if (s - m_ext >= HYST) begin m_dir = 1; m_ext = s; end
         else if (m_ext - s >= HYST) begin m_dir = -1; m_ext = s; end
      end else if (m_dir == 1) begin
         if (s > m_ext) m_ext = s;
         else if (m_ext - s >= HYST && g >= MIN_GAP) begin pk = 1; m_dir = -1; m_ext = s; end
      end else begin
         if (s < m_ext) m_ext = s;
         else if (s - m_ext >= HYST && g >= MIN_GAP) begin tr = 1; m_dir = 1; m_ext = s; end
      end
      m_gap = (pk || tr) ? 0 : g;
      if (pk) begin
         m_np++;
         if (m_seen) begin
            m_interval = sat(m_icnt + 1, IMAX);
            m_iv = 1;
         end
         m_seen = 1;
         m_icnt = 0;
      end else begin
         m_icnt = sat(m_icnt + 1, IMAX);
      end
      if (tr) m_nt++;
      m_pk = pk;
      m_tr = tr;
   endtask

   task automatic step(input bit v, input int s, input bit c);
      @(negedge clk);
      sample_valid = v;
      sample       = WIDTH'(s);
      clear        = c;
      @(posedge clk);
      #1;
      model_step(v, s, c);
      sample_valid = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL reset_state: got %h want 0", obs); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL reset_release: got %h want %h", obs, expv()); end
   endtask

   task automatic test_ramp();
      for (int i = 0; i <= 10; i++) begin
         step(1, i * 10, 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL ramp_up i=%0d: got %h want %h", i, obs, expv()); end
      end
      for (int i = 9; i >= 0; i--) begin
         step(1, i * 10, 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL ramp_down i=%0d: got %h want %h", i, obs, expv()); end
         if (i == 9) begin
            tests++;
            if (peak_pulse !== 1'b1 || num_peaks !== 10'd1)
               begin fails++; $display("FAIL ramp_peak: got pulse=%b cnt=%0d want 1/1", peak_pulse, num_peaks); end
         end
      end
      step(1, 4, 0);
      tests++;
      if (trough_pulse !== 1'b0) begin fails++; $display("FAIL ramp_trough_early: got %b want 0", trough_pulse); end
      step(1, 8, 0);
      tests++;
      if (trough_pulse !== 1'b1 || num_troughs !== 10'd1)
         begin fails++; $display("FAIL ramp_trough: got pulse=%b cnt=%0d want 1/1", trough_pulse, num_troughs); end
   endtask

   task automatic test_seek_alternate();
      step(0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         step(1, (i % 2 == 0) ? 50 : 55, 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL seek i=%0d: got %h want %h", i, obs, expv()); end
      end
      tests++;
      if (num_peaks !== '0 || num_troughs !== '0)
         begin fails++; $display("FAIL seek_counts: got %0d/%0d want 0/0", num_peaks, num_troughs); end
   endtask

   task automatic test_triangle();
      step(0, 0, 1);
      for (int n = 0; n < 60; n++) begin
         int j;
         j = n % 20;
         step(1, (j <= 10) ? j * 10 : (20 - j) * 10, 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL triangle n=%0d: got %h want %h", n, obs, expv()); end
         if (m_pk && m_np == 1) begin
            tests++;
            if (interval_valid !== 1'b0) begin fails++; $display("FAIL tri_first_iv: got %b want 0", interval_valid); end
         end
         if (m_pk && m_np == 2) begin
            tests++;
            if (interval !== (IEN ? 16'd20 : 16'd0) || interval_valid !== IEN)
               begin fails++; $display("FAIL tri_interval: got %0d/%b want %0d/%b", interval, interval_valid, IEN ? 20 : 0, IEN); end
         end
      end
   endtask

   task automatic test_gap_defer();
      int seq[8] = '{0, 20, 40, 30, 28, 40, 40, 40};
      bit want_tr[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      step(0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(1, seq[i], 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL gap i=%0d: got %h want %h", i, obs, expv()); end
         tests++;
         if (trough_pulse !== want_tr[i]) begin fails++; $display("FAIL gap_trough i=%0d: got %b want %b", i, trough_pulse, want_tr[i]); end
      end
   endtask

   task automatic test_saturation();
      int k;
      k = 0;
      step(0, 0, 1);
      for (int n = 0; n < 120; n++) begin
         int j;
         j = n % 20;
         step(1, (j <= 10) ? j * 50 : (20 - j) * 50, 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL sat n=%0d: got %h want %h", n, obs, expv()); end
         if (c2_pk === 1'b1) begin
            k++;
            tests++;
            if (c2_np !== 2'(sat(k, 3))) begin fails++; $display("FAIL sat_cnt peak %0d: got %0d want %0d", k, c2_np, sat(k, 3)); end
         end
      end
      tests++;
      if (k != 6) begin fails++; $display("FAIL sat_npeaks: got %0d want 6", k); end
   endtask

   task automatic test_clear_reset();
      int seq[6] = '{500, 505, 520, 400, 390, 380};
      step(0, 0, 1);
      step(1, 0, 0);
      step(1, 20, 0);
      step(1, 40, 0);
      step(1, 60, 1);
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL clear_outputs: got %h want 0", obs); end
      for (int i = 0; i < 5; i++) begin
         step(1, seq[i], 0);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL after_clear i=%0d: got %h want %h", i, obs, expv()); end
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL reset_mid: got %h want 0", obs); end
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      step(1, 700, 0);
      step(1, 710, 0);
      step(1, 600, 0);
      tests++;
      if (obs !== expv()) begin fails++; $display("FAIL after_reset: got %h want %h", obs, expv()); end
   endtask

   task automatic test_back_to_back();
      int s;
      s = 512;
      step(0, 0, 1);
      for (int n = 0; n < 3000; n++) begin
         bit v, c;
         v = (n < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) == 0)
            s = ($urandom_range(0, 1) == 1) ? 1023 : 0;
         else
            s = s + $urandom_range(0, 40) - 20;
         if (s < 0) s = 0;
         if (s > 1023) s = 1023;
         step(v, s, c);
         tests++;
         if (obs !== expv()) begin fails++; $display("FAIL random n=%0d: got %h want %h", n, obs, expv()); end
         tests++;
         if (peak_pulse === 1'b1 && trough_pulse === 1'b1) begin fails++; $display("FAIL both_pulses n=%0d: got 11 want not both", n); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_seek_alternate();
      test_triangle();
      test_gap_defer();
      test_saturation();
      test_clear_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
